burst_axi_master: RTL and testbench
===================================

Name: burst_axi_master

Overview:
Parametrised successor to the single-beat AXI4 master. It accepts one command at a time: read or write, INCR burst of 1..MAX_LEN beats. Write data comes from a valid/ready stream, read data goes out on a valid/ready stream, and the block returns one completion response per command. It sits between CPU/DMA-side logic and an AXI4 interconnect. It validates alignment, burst length and 4 KiB crossing before issuing anything on the bus.

Parameters:
DATA_WIDTH, 32, AXI data bus width in bits; 32 or 64 only.
ADDR_WIDTH, 32, address width.
MAX_LEN, 16, maximum beats per burst (1..256).

Ports:
i_clk  in  1  clock.
i_rst  in  1  synchronous active-high reset.
i_cmd_valid  in  1  command valid.
o_cmd_ready  out  1  high only in S_IDLE.
i_cmd_write  in  1  1 = write, 0 = read.
i_cmd_addr  in  ADDR_WIDTH  start byte address.
i_cmd_size  in  3  log2 bytes per beat.
i_cmd_len  in  8  beats minus 1 (AXI encoding).
i_wd_valid / o_wd_ready / i_wd_data  in/out/in  1/1/DATA_WIDTH  write data stream, LSB-aligned for narrow beats.
o_rd_valid / i_rd_ready / o_rd_data / o_rd_last  out/in/out/out  1/1/DATA_WIDTH/1  read data stream, LSB-aligned, masked to size.
o_rsp_valid  out  1  completion pulse, held until i_rsp_ready.
i_rsp_ready  in  1  response accept.
o_rsp_code  out  2  OKAY/EXOKAY/SLVERR/DECERR, worst-of-burst.
o_rsp_invalid  out  1  command rejected without a bus transaction.
o_busy  out  1  state != S_IDLE.
m_axi_aw*, m_axi_w*, m_axi_b*, m_axi_ar*, m_axi_r*  AXI4 master channels. wstrb is DATA_WIDTH/8 bits. awburst/arburst = INCR, cache = 4'b0011, prot/lock/qos = 0.

Behaviour:
- Reset (i_rst sampled high at the clock edge): state S_IDLE. All valid outputs, o_busy, o_rsp_invalid and beat counter are 0. o_rsp_code = OKAY. Data registers are 0. Reset mid-burst abandons the transaction immediately; the bus is not drained.
- Command acceptance is a handshake: i_cmd_valid & o_cmd_ready in S_IDLE. Command fields are registered on acceptance.
- Invalid if any of the following holds:
  - size > log2(DATA_WIDTH/8);
  - addr not aligned to size;
  - len+1 > MAX_LEN;
  - len > 0 with size != full width;
  - (addr[11:0] + (len+1) << size) > 4096.
- An invalid command goes to S_RSP with o_rsp_invalid = 1 and code = SLVERR. No AXI activity occurs.
- States and transitions:
  - S_IDLE → S_AW (write) or S_AR (read) on acceptance.
  - S_AW: awvalid = 1 until awready, then → S_W. AW and W are not overlapped.
  - S_W: wvalid = i_wd_valid, o_wd_ready = wready. Beat counter increments on each handshake. wlast = (count == len). The handshake that carries wlast → S_B.
  - S_B: bready = 1. On bvalid, latch bresp → S_RSP.
  - S_AR: arvalid until arready → S_R.
  - S_R: rready = i_rd_ready. o_rd_valid = rvalid. o_rd_data = (rdata >> 8*offset) & size mask, combinational pass-through with no buffering. Worst resp is accumulated, with DECERR > SLVERR > EXOKAY > OKAY. Beat with rlast, or count == len → S_RSP. An rlast before count == len forces the sticky code to SLVERR.
  - S_RSP: o_rsp_valid = 1. On i_rsp_ready → S_IDLE, and invalid/code are cleared on the next command.
- Strobe = size mask << addr[log2(DATA_WIDTH/8)-1:0]. wdata = i_wd_data << 8*offset. Both apply only to single narrow beats; full-width beats use all-ones strobe.
- Beat counter is 8 bits and never wraps, because MAX_LEN is checked at acceptance.
- All AXI valids stay stable until their handshake, regardless of upstream stream stalls.
- Minimum write latency: accept → AW 1 cycle → W len+1 cycles → B ≥1 cycle → RSP.

Optional Feature:
BURST_AXI_MASTER_LATENCY_EN.
- Defined: adds output o_latency[31:0], the cycle count from command acceptance to o_rsp_valid rising. It updates when o_rsp_valid rises, saturates at 32'hFFFF_FFFF, and resets to 0.
- Undefined: port absent and no counter logic.

Decomposition:
- Package axi_pkg holds:
  - axi_resp_e (OKAY, EXOKAY, SLVERR, DECERR);
  - axi_size_e;
  - AXI_BURST_INCR and AXI_CACHE_DEFAULT constants;
  - the state_e enum;
  - a worst-response function.
- One sub-module, axi_cmd_check: purely combinational validity check (alignment, length, 4 KiB crossing) with the parameters passed through. It is unit-testable in isolation.

Test Plan:
1. 32-bit single-word write to 0x100 with data 0xDEADBEEF, awready/wready/bvalid immediate → wstrb 4'hF, wlast on the only beat, response OKAY, invalid = 0.
2. Byte write to 0x103 with data 0xAB → wstrb 4'b1000, wdata 0xAB000000. Byte read of 0x103 with rdata 0x12345678 → o_rd_data 0x12.
3. 8-beat write burst (len = 7) with i_wd_valid toggling every other cycle → exactly 8 W handshakes, wlast only on the 8th, awlen = 7.
4. 4-beat read with rresp OKAY, SLVERR, OKAY, OKAY and i_rd_ready stalled 3 cycles mid-burst → all 4 beats delivered in order, o_rd_last on the 4th, o_rsp_code = SLVERR.
5. Invalid commands → o_rsp_invalid = 1, code SLVERR, no aw/arvalid ever asserted:
   - addr 0xFF8, len 3, size 2 (4 KiB crossing);
   - len = MAX_LEN;
   - word at 0x2.
6. Assert i_rst during S_W of a 4-beat write → next cycle state is S_IDLE, all valids 0, o_cmd_ready = 1.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI4 types, constants and the FSM state encoding for burst_axi_master.
package axi_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    SIZE_1B   = 3'd0,
    SIZE_2B   = 3'd1,
    SIZE_4B   = 3'd2,
    SIZE_8B   = 3'd3,
    SIZE_16B  = 3'd4,
    SIZE_32B  = 3'd5,
    SIZE_64B  = 3'd6,
    SIZE_128B = 3'd7
  } axi_size_e;

  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AW   = 3'd1,
    S_W    = 3'd2,
    S_B    = 3'd3,
    S_AR   = 3'd4,
    S_R    = 3'd5,
    S_RSP  = 3'd6
  } state_e;

  // The response encoding already increases with severity.
  function automatic axi_resp_e worst_resp(input axi_resp_e a, input axi_resp_e b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_cmd_check.sv
// Combinational command validity check: size, alignment, burst length and 4 KiB crossing.
module axi_cmd_check
  import axi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MAX_LEN    = 16
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [2:0]            i_size,
  input  logic [7:0]            i_len,
  output logic                  o_invalid
);

  localparam int unsigned FullSize = $clog2(DATA_WIDTH / 8);

  logic [8:0]  beats;
  logic [7:0]  align_mask;
  logic [16:0] end_off;
  logic        size_bad, align_bad, len_bad, narrow_burst, crosses_4k;

  always_comb begin
    beats        = {1'b0, i_len} + 9'd1;
    align_mask   = (8'd1 << i_size) - 8'd1;
    end_off      = 17'(i_addr[11:0]) + (17'(beats) << i_size);
    size_bad     = 32'(i_size) > FullSize;
    align_bad    = (i_addr[7:0] & align_mask) != 8'd0;
    len_bad      = 32'(beats) > MAX_LEN;
    narrow_burst = (i_len != 8'd0) && (32'(i_size) != FullSize);
    crosses_4k   = end_off > 17'd4096;
    o_invalid    = size_bad | align_bad | len_bad | narrow_burst | crosses_4k;
  end

endmodule

// File: rtl/burst_axi_master.sv
// Single-command AXI4 INCR burst master with write/read data streams and one response per command.
// Optional: define BURST_AXI_MASTER_LATENCY_EN to add the o_latency accept-to-response counter.
module burst_axi_master
  import axi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MAX_LEN    = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic                    i_cmd_write,
  input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
  input  logic [2:0]              i_cmd_size,
  input  logic [7:0]              i_cmd_len,
  input  logic                    i_wd_valid,
  output logic                    o_wd_ready,
  input  logic [DATA_WIDTH-1:0]   i_wd_data,
  output logic                    o_rd_valid,
  input  logic                    i_rd_ready,
  output logic [DATA_WIDTH-1:0]   o_rd_data,
  output logic                    o_rd_last,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [1:0]              o_rsp_code,
  output logic                    o_rsp_invalid,
`ifdef BURST_AXI_MASTER_LATENCY_EN
  output logic [31:0]             o_latency,
`endif
  output logic                    o_busy,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic [3:0]              m_axi_awqos,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arlock,
  output logic [3:0]              m_axi_arcache,
  output logic [2:0]              m_axi_arprot,
  output logic [3:0]              m_axi_arqos,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned OffW  = $clog2(StrbW);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            size_q, size_d;
  logic [7:0]            len_q, len_d;
  logic [7:0]            cnt_q, cnt_d;
  axi_resp_e             resp_q, resp_d;
  logic                  invalid_q, invalid_d;

  logic                  cmd_invalid;
  logic                  last_beat;
  logic [OffW-1:0]       off;
  logic [StrbW-1:0]      strb_mask;
  logic [DATA_WIDTH-1:0] data_mask;

  axi_cmd_check #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .MAX_LEN   (MAX_LEN)
  ) u_cmd_check (
    .i_addr   (i_cmd_addr),
    .i_size   (i_cmd_size),
    .i_len    (i_cmd_len),
    .o_invalid(cmd_invalid)
  );

  assign last_beat = (cnt_q == len_q);

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    size_d        = size_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    resp_d        = resp_q;
    invalid_d     = invalid_q;
    o_cmd_ready   = 1'b0;
    o_wd_ready    = 1'b0;
    o_rd_valid    = 1'b0;
    o_rd_last     = 1'b0;
    o_rsp_valid   = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        o_cmd_ready = 1'b1;
        if (i_cmd_valid) begin
          addr_d = i_cmd_addr;
          size_d = i_cmd_size;
          len_d  = i_cmd_len;
          cnt_d  = 8'd0;
          if (cmd_invalid) begin
            invalid_d = 1'b1;
            resp_d    = SLVERR;
            state_d   = S_RSP;
          end else begin
            invalid_d = 1'b0;
            resp_d    = OKAY;
            state_d   = i_cmd_write ? S_AW : S_AR;
          end
        end
      end
      S_AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_d = S_W;
      end
      S_W: begin
        m_axi_wvalid = i_wd_valid;
        m_axi_wlast  = last_beat;
        o_wd_ready   = m_axi_wready;
        if (i_wd_valid && m_axi_wready) begin
          cnt_d = cnt_q + 8'd1;
          if (last_beat) state_d = S_B;
        end
      end
      S_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          resp_d  = axi_resp_e'(m_axi_bresp);
          state_d = S_RSP;
        end
      end
      S_AR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_d = S_R;
      end
      S_R: begin
        m_axi_rready = i_rd_ready;
        o_rd_valid   = m_axi_rvalid;
        o_rd_last    = m_axi_rvalid & (m_axi_rlast | last_beat);
        if (m_axi_rvalid && i_rd_ready) begin
          cnt_d  = cnt_q + 8'd1;
          resp_d = worst_resp(resp_q, axi_resp_e'(m_axi_rresp));
          // A short burst from the slave is an error, but never hides a DECERR.
          if (m_axi_rlast && !last_beat) resp_d = worst_resp(resp_d, SLVERR);
          if (m_axi_rlast || last_beat) state_d = S_RSP;
        end
      end
      S_RSP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Narrow single beats are placed on their byte lane; full-width beats have offset 0.
  always_comb begin
    off = addr_q[OffW-1:0];
    for (int i = 0; i < StrbW; i++) begin
      strb_mask[i]       = (32'(i) >> size_q) == 32'd0;
      data_mask[8*i +: 8] = {8{strb_mask[i]}};
    end
    m_axi_wstrb = strb_mask << off;
    m_axi_wdata = i_wd_data << {off, 3'b000};
    o_rd_data   = (m_axi_rdata >> {off, 3'b000}) & data_mask;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      size_q    <= 3'd0;
      len_q     <= 8'd0;
      cnt_q     <= 8'd0;
      resp_q    <= OKAY;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      resp_q    <= resp_d;
      invalid_q <= invalid_d;
    end
  end

`ifdef BURST_AXI_MASTER_LATENCY_EN
  logic [31:0] cyc_q, lat_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cyc_q <= 32'd0;
      lat_q <= 32'd0;
    end else begin
      if (state_q == S_IDLE && i_cmd_valid) cyc_q <= 32'd1;
      else if (cyc_q != 32'hFFFF_FFFF)      cyc_q <= cyc_q + 32'd1;
      if (state_d == S_RSP && state_q != S_RSP) begin
        lat_q <= (state_q == S_IDLE) ? 32'd1 : cyc_q;
      end
    end
  end

  assign o_latency = lat_q;
`endif

  assign o_rsp_code    = resp_q;
  assign o_rsp_invalid = invalid_q;
  assign o_busy        = (state_q != S_IDLE);

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = size_q;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = AXI_CACHE_DEFAULT;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awqos   = 4'b0000;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = size_q;
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = AXI_CACHE_DEFAULT;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arqos   = 4'b0000;

endmodule

// File: tb/tb_burst_axi_master.sv
// Directed bench for burst_axi_master: single-beat vector table plus burst, stall and reset sequences.
module tb_burst_axi_master;
  import axi_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int ML = 16;

  logic          i_clk, i_rst;
  logic          i_cmd_valid, o_cmd_ready, i_cmd_write;
  logic [AW-1:0] i_cmd_addr;
  logic [2:0]    i_cmd_size;
  logic [7:0]    i_cmd_len;
  logic          i_wd_valid, o_wd_ready;
  logic [DW-1:0] i_wd_data;
  logic          o_rd_valid, i_rd_ready, o_rd_last;
  logic [DW-1:0] o_rd_data;
  logic          o_rsp_valid, i_rsp_ready, o_rsp_invalid, o_busy;
  logic [1:0]    o_rsp_code;
`ifdef BURST_AXI_MASTER_LATENCY_EN
  logic [31:0]   o_latency;
`endif
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0]    m_axi_awlen, m_axi_arlen;
  logic [2:0]    m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
  logic [1:0]    m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
  logic          m_axi_awlock, m_axi_arlock;
  logic [3:0]    m_axi_awcache, m_axi_arcache, m_axi_awqos, m_axi_arqos;
  logic          m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [DW-1:0] m_axi_wdata, m_axi_rdata;
  logic [3:0]    m_axi_wstrb;
  logic          m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;

  burst_axi_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_LEN(ML)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
    .i_cmd_addr(i_cmd_addr), .i_cmd_size(i_cmd_size), .i_cmd_len(i_cmd_len),
    .i_wd_valid(i_wd_valid), .o_wd_ready(o_wd_ready), .i_wd_data(i_wd_data),
    .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready), .o_rd_data(o_rd_data),
    .o_rd_last(o_rd_last), .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_code(o_rsp_code), .o_rsp_invalid(o_rsp_invalid),
`ifdef BURST_AXI_MASTER_LATENCY_EN
    .o_latency(o_latency),
`endif
    .o_busy(o_busy),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
    .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [7:0]  len;
    logic [31:0] data;      // write stream data or slave rdata
    logic [1:0]  resp;      // slave bresp/rresp
    logic        exp_inv;
    logic [1:0]  exp_code;
    logic [3:0]  exp_strb;
    logic [31:0] exp_data;  // expected wdata (write) or o_rd_data (read)
  } vec_t;

  vec_t vecs[12];

  int n_tests = 0;
  int n_fail  = 0;

  // Slave/stream knobs and captures shared by the transaction engine.
  logic        wd_toggle;
  int          stall_beat, stall_len;
  logic [1:0]  rresp_tab[16];
  logic [31:0] wd_base, rd_base;
  int          aw_cnt, ar_cnt, w_hs, wlast_cnt, wlast_idx, r_hs, rlast_cnt, rlast_idx;
  logic [7:0]  awlen_cap;
  logic [3:0]  wstrb0;
  logic [31:0] w_data[16];
  logic [31:0] r_data[16];
  logic [1:0]  code_cap;
  logic        inv_cap;
  logic        timed_out;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [7:0] len);
    @(negedge i_clk);
    i_cmd_valid = 1'b1;
    i_cmd_write = wr;
    i_cmd_addr  = addr;
    i_cmd_size  = size;
    i_cmd_len   = len;
    #1;
    check("cmd_ready_idle", 32'(o_cmd_ready), 32'd1);
    @(negedge i_clk);
    i_cmd_valid = 1'b0;
  endtask

  // Drives the slave and streams each cycle until the response appears, then accepts it.
  task automatic run_txn(input logic [7:0] len);
    int stall_left;
    logic done;
    aw_cnt = 0; ar_cnt = 0; w_hs = 0; wlast_cnt = 0; wlast_idx = -1;
    r_hs = 0; rlast_cnt = 0; rlast_idx = -1; awlen_cap = 8'hxx; wstrb0 = 4'h0;
    stall_left = stall_len;
    done = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      i_wd_valid  = wd_toggle ? cyc[0] : 1'b1;
      i_wd_data   = wd_base + 32'(w_hs);
      m_axi_rdata = rd_base + 32'(r_hs);
      m_axi_rresp = rresp_tab[r_hs[3:0]];
      m_axi_rlast = (r_hs == int'(len));
      if (r_hs == stall_beat && stall_left > 0) begin
        i_rd_ready = 1'b0;
        stall_left--;
      end else begin
        i_rd_ready = 1'b1;
      end
      #1;
      if (m_axi_awvalid) begin aw_cnt++; awlen_cap = m_axi_awlen; end
      if (m_axi_arvalid) ar_cnt++;
      if (m_axi_wvalid && m_axi_wready) begin
        if (w_hs == 0) wstrb0 = m_axi_wstrb;
        w_data[w_hs[3:0]] = m_axi_wdata;
        if (m_axi_wlast) begin wlast_cnt++; wlast_idx = w_hs; end
        w_hs++;
      end
      if (o_rd_valid && i_rd_ready) begin
        r_data[r_hs[3:0]] = o_rd_data;
        if (o_rd_last) begin rlast_cnt++; rlast_idx = r_hs; end
        r_hs++;
      end
      if (o_rsp_valid) begin
        code_cap = o_rsp_code;
        inv_cap  = o_rsp_invalid;
        done     = 1'b1;
        break;
      end
      @(negedge i_clk);
    end
    timed_out = !done;
    @(negedge i_clk);
    i_rsp_ready = 1'b1;
    @(negedge i_clk);
    i_rsp_ready = 1'b0;
    #1;
    check("busy_after_rsp", 32'(o_busy), 32'd0);
  endtask

  initial begin
    i_rst = 1'b1; i_cmd_valid = 1'b0; i_cmd_write = 1'b0; i_cmd_addr = '0;
    i_cmd_size = 3'd0; i_cmd_len = 8'd0; i_wd_valid = 1'b0; i_wd_data = '0;
    i_rd_ready = 1'b0; i_rsp_ready = 1'b0;
    m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_bvalid = 1'b1; m_axi_bresp = OKAY;
    m_axi_arready = 1'b1; m_axi_rvalid = 1'b1; m_axi_rdata = '0; m_axi_rresp = OKAY;
    m_axi_rlast = 1'b0;
    wd_toggle = 1'b0; stall_beat = -1; stall_len = 0; wd_base = '0; rd_base = '0;
    foreach (rresp_tab[i]) rresp_tab[i] = OKAY;

    //            wr    addr        sz    len    data          resp    inv   code    strb   exp
    vecs[0]  = '{1'b1, 32'h100, 3'd2, 8'd0, 32'hDEADBEEF, OKAY, 1'b0, OKAY, 4'hF,
                 32'hDEADBEEF};
    vecs[1]  = '{1'b1, 32'h103, 3'd0, 8'd0, 32'h000000AB, OKAY, 1'b0, OKAY, 4'b1000,
                 32'hAB000000};
    vecs[2]  = '{1'b0, 32'h103, 3'd0, 8'd0, 32'h12345678, OKAY, 1'b0, OKAY, 4'h0,
                 32'h00000012};
    vecs[3]  = '{1'b0, 32'h102, 3'd1, 8'd0, 32'h12345678, OKAY, 1'b0, OKAY, 4'h0,
                 32'h00001234};
    vecs[4]  = '{1'b1, 32'h202, 3'd1, 8'd0, 32'h0000BEEF, OKAY, 1'b0, OKAY, 4'b1100,
                 32'hBEEF0000};
    vecs[5]  = '{1'b1, 32'hFF8, 3'd2, 8'd3, 32'h0, OKAY, 1'b1, SLVERR, 4'h0, 32'h0};
    vecs[6]  = '{1'b0, 32'h000, 3'd2, 8'd16, 32'h0, OKAY, 1'b1, SLVERR, 4'h0, 32'h0};
    vecs[7]  = '{1'b1, 32'h002, 3'd2, 8'd0, 32'h0, OKAY, 1'b1, SLVERR, 4'h0, 32'h0};
    vecs[8]  = '{1'b0, 32'h000, 3'd3, 8'd0, 32'h0, OKAY, 1'b1, SLVERR, 4'h0, 32'h0};
    vecs[9]  = '{1'b1, 32'h010, 3'd0, 8'd1, 32'h0, OKAY, 1'b1, SLVERR, 4'h0, 32'h0};
    vecs[10] = '{1'b0, 32'hFFC, 3'd2, 8'd0, 32'hCAFEF00D, EXOKAY, 1'b0, EXOKAY, 4'h0,
                 32'hCAFEF00D};
    vecs[11] = '{1'b1, 32'h400, 3'd2, 8'd0, 32'h00000001, DECERR, 1'b0, DECERR, 4'hF,
                 32'h00000001};

    // Reset state
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_cmd_ready", 32'(o_cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("rst_rsp_code", 32'(o_rsp_code), 32'(OKAY));
    check("rst_rsp_invalid", 32'(o_rsp_invalid), 32'd0);
    check("rst_valids", {29'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 32'd0);
    i_rst = 1'b0;

    foreach (vecs[i]) begin
      m_axi_bresp  = vecs[i].resp;
      rresp_tab[0] = vecs[i].resp;
      wd_base      = vecs[i].data;
      rd_base      = vecs[i].data;
      issue(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].len);
      run_txn(vecs[i].len);
      check($sformatf("v%0d_timeout", i), 32'(timed_out), 32'd0);
      check($sformatf("v%0d_invalid", i), 32'(inv_cap), 32'(vecs[i].exp_inv));
      check($sformatf("v%0d_code", i), 32'(code_cap), 32'(vecs[i].exp_code));
      if (vecs[i].exp_inv) begin
        check($sformatf("v%0d_no_bus", i), 32'(aw_cnt + ar_cnt + w_hs), 32'd0);
      end else if (vecs[i].wr) begin
        check($sformatf("v%0d_wstrb", i), 32'(wstrb0), 32'(vecs[i].exp_strb));
        check($sformatf("v%0d_wdata", i), w_data[0], vecs[i].exp_data);
        check($sformatf("v%0d_wbeats", i), 32'(w_hs), 32'd1);
        check($sformatf("v%0d_wlast", i), 32'(wlast_idx), 32'd0);
      end else begin
        check($sformatf("v%0d_rdata", i), r_data[0], vecs[i].exp_data);
        check($sformatf("v%0d_rbeats", i), 32'(r_hs), 32'd1);
        check($sformatf("v%0d_rlast", i), 32'(rlast_idx), 32'd0);
      end
    end
    m_axi_bresp  = OKAY;
    rresp_tab[0] = OKAY;

    // 8-beat write burst with a gappy write stream
    wd_toggle = 1'b1;
    wd_base   = 32'h1000_0000;
    issue(1'b1, 32'h1000, 3'd2, 8'd7);
    run_txn(8'd7);
    check("burst_w_timeout", 32'(timed_out), 32'd0);
    check("burst_w_awlen", 32'(awlen_cap), 32'd7);
    check("burst_w_beats", 32'(w_hs), 32'd8);
    check("burst_w_wlast_cnt", 32'(wlast_cnt), 32'd1);
    check("burst_w_wlast_idx", 32'(wlast_idx), 32'd7);
    check("burst_w_data0", w_data[0], 32'h1000_0000);
    check("burst_w_data7", w_data[7], 32'h1000_0007);
    check("burst_w_code", 32'(code_cap), 32'(OKAY));
    wd_toggle = 1'b0;

    // 4-beat read, SLVERR on beat 1, consumer stalls 3 cycles before beat 2
    rresp_tab[1] = SLVERR;
    stall_beat   = 2;
    stall_len    = 3;
    rd_base      = 32'hA000_0000;
    issue(1'b0, 32'h2000, 3'd2, 8'd3);
    run_txn(8'd3);
    check("burst_r_timeout", 32'(timed_out), 32'd0);
    check("burst_r_beats", 32'(r_hs), 32'd4);
    for (int b = 0; b < 4; b++) begin
      check($sformatf("burst_r_data%0d", b), r_data[b], 32'hA000_0000 + 32'(b));
    end
    check("burst_r_last_cnt", 32'(rlast_cnt), 32'd1);
    check("burst_r_last_idx", 32'(rlast_idx), 32'd3);
    check("burst_r_code", 32'(code_cap), 32'(SLVERR));
    check("burst_r_invalid", 32'(inv_cap), 32'd0);
    rresp_tab[1] = OKAY;
    stall_beat   = -1;
    stall_len    = 0;

    // Reset in the middle of the W phase of a 4-beat write
    begin
      int hs;
      hs = 0;
      wd_base = 32'h5000_0000;
      issue(1'b1, 32'h3000, 3'd2, 8'd3);
      i_wd_valid = 1'b1;
      i_wd_data  = wd_base;
      for (int c = 0; c < 20; c++) begin
        #1;
        if (m_axi_wvalid && m_axi_wready) hs++;
        if (hs == 3) break;
        @(negedge i_clk);
      end
      check("rst_mid_reached_w", 32'(hs), 32'd3);
      i_rst = 1'b1;
      @(posedge i_clk);
      #1;
      check("rst_mid_busy", 32'(o_busy), 32'd0);
      check("rst_mid_cmd_ready", 32'(o_cmd_ready), 32'd1);
      check("rst_mid_valids",
            {27'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, o_rsp_valid, o_wd_ready},
            32'd0);
      @(negedge i_clk);
      i_rst = 1'b0;
    end

    // Recovery: a 2-beat write must see a fresh beat counter
    wd_base = 32'h6000_0000;
    issue(1'b1, 32'h3000, 3'd2, 8'd1);
    run_txn(8'd1);
    check("post_rst_timeout", 32'(timed_out), 32'd0);
    check("post_rst_beats", 32'(w_hs), 32'd2);
    check("post_rst_wlast_idx", 32'(wlast_idx), 32'd1);
    check("post_rst_code", 32'(code_cap), 32'(OKAY));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
